// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the fetch-side redirect logic.
// State encoding and address constants.
package pipeline_pkg;

  localparam int ADDR_W = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    ST_RUN,
    ST_PENDING
  } redir_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target selection: jr > j/jal > branch.
// Purely combinational; all arithmetic wraps.
module pc_target_calc
  import pipeline_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          branch,
  input  logic [15:0]   jump_amount,
  input  logic          jump,
  input  logic [25:0]   jump_target,
  input  logic          jump_reg,
  input  logic [AW-1:0] jump_reg_addr,
  input  logic [AW-1:0] id_pc_plus4,
  output logic [AW-1:0] target,
  output logic          req,
  output logic          misalign
);

  logic [AW-1:0] br_off;
  logic [AW-1:0] br_tgt;
  logic [AW-1:0] j_tgt;
  logic [AW-1:0] jr_tgt;

  assign br_off = {{(AW-18){jump_amount[15]}}, jump_amount, 2'b00};
  assign br_tgt = id_pc_plus4 + br_off;
  assign j_tgt  = {id_pc_plus4[AW-1:28], jump_target, 2'b00};
  assign jr_tgt = {jump_reg_addr[AW-1:2], 2'b00};

  assign req      = jump_reg | jump | branch;
  assign misalign = jump_reg & (jump_reg_addr[1:0] != 2'b00);

  // priority select of the redirect target
  always_comb begin
    target = br_tgt;
    if (jump_reg)
      target = jr_tgt;
    else if (jump)
      target = j_tgt;
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: applies ID-stage redirects, holds
// them across stalls, and flushes the wrong-path fetch.
module pc_redirect_unit
  import pipeline_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Stall,
  input  logic              Branch,
  input  logic [15:0]       JumpAmount,
  input  logic              Jump,
  input  logic [25:0]       JumpTarget,
  input  logic              JumpReg,
  input  logic [ADDR_W-1:0] JumpRegAddr,
  input  logic [ADDR_W-1:0] ID_PCPlus4,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus4,
  output logic              IFID_Flush,
  output logic              Pending,
  output logic              MisalignErr,
  output logic [CNT_W-1:0]  RedirectCount
);

  redir_state_t      state, state_n;
  logic [ADDR_W-1:0] pend_tgt, pend_tgt_n;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] target;
  logic              req;
  logic              misalign;
  logic              apply;
  logic              mis_n;

  pc_target_calc #(.AW(ADDR_W)) u_calc (
    .branch        (Branch),
    .jump_amount   (JumpAmount),
    .jump          (Jump),
    .jump_target   (JumpTarget),
    .jump_reg      (JumpReg),
    .jump_reg_addr (JumpRegAddr),
    .id_pc_plus4   (ID_PCPlus4),
    .target        (target),
    .req           (req),
    .misalign      (misalign)
  );

  assign PCPlus4 = PC + ADDR_W'(INSTR_BYTES);
  assign Pending = (state == ST_PENDING);

  // next-state, next-PC and flush decision
  always_comb begin
    state_n    = state;
    pc_n       = PC;
    pend_tgt_n = pend_tgt;
    IFID_Flush = 1'b0;
    apply      = 1'b0;
    mis_n      = 1'b0;
    case (state)
      ST_RUN: begin
        mis_n = misalign;
        if (!Stall) begin
          if (req) begin
            pc_n       = target;
            IFID_Flush = 1'b1;
            apply      = 1'b1;
          end else begin
            pc_n = PCPlus4;
          end
        end else if (req) begin
          pend_tgt_n = target;
          state_n    = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!Stall) begin
          pc_n       = pend_tgt;
          IFID_Flush = 1'b1;
          apply      = 1'b1;
          state_n    = ST_RUN;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

  // state, PC, held target and error pulse registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_RUN;
      PC          <= RESET_PC[ADDR_W-1:0];
      pend_tgt    <= '0;
      MisalignErr <= 1'b0;
    end else begin
      state       <= state_n;
      PC          <= pc_n;
      pend_tgt    <= pend_tgt_n;
      MisalignErr <= mis_n;
    end
  end

  // saturating count of applied redirects
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      RedirectCount <= '0;
    else if (apply && (RedirectCount != '1))
      RedirectCount <= RedirectCount + 1'b1;
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed
// scenarios plus randomized cycles against a reference model.
module tb_pc_redirect_unit;

  logic        Clk;
  logic        Reset_n;
  logic        Stall;
  logic        Branch;
  logic [15:0] JumpAmount;
  logic        Jump;
  logic [25:0] JumpTarget;
  logic        JumpReg;
  logic [31:0] JumpRegAddr;
  logic [31:0] ID_PCPlus4;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        IFID_Flush;
  logic        Pending;
  logic        MisalignErr;
  logic [15:0] RedirectCount;

  int passed = 0;
  int total  = 0;

  pc_redirect_unit dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Stall         (Stall),
    .Branch        (Branch),
    .JumpAmount    (JumpAmount),
    .Jump          (Jump),
    .JumpTarget    (JumpTarget),
    .JumpReg       (JumpReg),
    .JumpRegAddr   (JumpRegAddr),
    .ID_PCPlus4    (ID_PCPlus4),
    .PC            (PC),
    .PCPlus4       (PCPlus4),
    .IFID_Flush    (IFID_Flush),
    .Pending       (Pending),
    .MisalignErr   (MisalignErr),
    .RedirectCount (RedirectCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // reference model state
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;
  int          m_cnt;
  bit          m_mis;

  function automatic logic [31:0] model_target();
    longint t;
    if (JumpReg)
      return JumpRegAddr & 32'hFFFF_FFFC;
    if (Jump)
      return (ID_PCPlus4 & 32'hF000_0000) | (32'(JumpTarget) * 4);
    t = longint'(ID_PCPlus4) + longint'($signed(JumpAmount)) * 4;
    return t[31:0];
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 0; m_tgt = 32'h0; m_cnt = 0; m_mis = 0;
  endtask

  task automatic model_step();
    bit rq;
    logic [31:0] t;
    rq = JumpReg | Jump | Branch;
    t  = model_target();
    if (!m_pend) begin
      m_mis = rq && JumpReg && (JumpRegAddr[1:0] != 2'b00);
      if (!Stall) begin
        if (rq) begin
          m_pc = t;
          if (m_cnt < 65535) m_cnt++;
        end else m_pc = m_pc + 4;
      end else if (rq) begin
        m_pend = 1; m_tgt = t;
      end
    end else begin
      m_mis = 0;
      if (!Stall) begin
        m_pc = m_tgt; m_pend = 0;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic clear_in();
    Stall = 0; Branch = 0; JumpAmount = 0; Jump = 0; JumpTarget = 0;
    JumpReg = 0; JumpRegAddr = 0; ID_PCPlus4 = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 0;
    #3;
    Reset_n = 1;
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    Reset_n = 0;
    #12;
    total++; if (PC !== 32'h0) $display("FAIL rst_pc got %h want %h", PC, 32'h0); else passed++;
    total++; if (Pending !== 1'b0) $display("FAIL rst_pending got %b want 0", Pending); else passed++;
    total++; if (RedirectCount !== 16'h0) $display("FAIL rst_cnt got %h want 0", RedirectCount); else passed++;
    total++; if (MisalignErr !== 1'b0) $display("FAIL rst_mis got %b want 0", MisalignErr); else passed++;
    Reset_n = 1;
    tick();
    // PC has stepped once since release
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (PC !== 32'(4 * (i + 1))) $display("FAIL seq_pc%0d got %h want %h", i, PC, 32'(4 * (i + 1))); else passed++;
      total++; if (IFID_Flush !== 1'b0) $display("FAIL seq_flush%0d got %b want 0", i, IFID_Flush); else passed++;
    end
    total++; if (RedirectCount !== 16'h0) $display("FAIL seq_cnt got %h want 0", RedirectCount); else passed++;
  endtask

  task automatic test_branch_back();
    do_reset();
    total++; if (PCPlus4 !== 32'h4) $display("FAIL pcplus4 got %h want 4", PCPlus4); else passed++;
    ID_PCPlus4 = 32'h100; Branch = 1; JumpAmount = 16'hFFFE;
    #1;
    total++; if (IFID_Flush !== 1'b1) $display("FAIL br_flush got %b want 1", IFID_Flush); else passed++;
    tick();
    clear_in();
    #1;
    total++; if (PC !== 32'hF8) $display("FAIL br_pc got %h want f8", PC); else passed++;
    total++; if (RedirectCount !== 16'd1) $display("FAIL br_cnt got %0d want 1", RedirectCount); else passed++;
    total++; if (IFID_Flush !== 1'b0) $display("FAIL br_noflush got %b want 0", IFID_Flush); else passed++;
  endtask

  task automatic test_stall_pending();
    logic [31:0] held;
    held = PC;
    Branch = 1; JumpAmount = 16'd4; ID_PCPlus4 = 32'h40; Stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (IFID_Flush !== 1'b0) $display("FAIL st_flush%0d got %b want 0", i, IFID_Flush); else passed++;
      tick();
      total++; if (PC !== held) $display("FAIL st_pc%0d got %h want %h", i, PC, held); else passed++;
      total++; if (Pending !== 1'b1) $display("FAIL st_pend%0d got %b want 1", i, Pending); else passed++;
    end
    Stall = 0;
    #1;
    total++; if (IFID_Flush !== 1'b1) $display("FAIL st_rel_flush got %b want 1", IFID_Flush); else passed++;
    tick();
    clear_in();
    #1;
    total++; if (PC !== 32'h50) $display("FAIL st_rel_pc got %h want 50", PC); else passed++;
    total++; if (Pending !== 1'b0) $display("FAIL st_rel_pend got %b want 0", Pending); else passed++;
    total++; if (IFID_Flush !== 1'b0) $display("FAIL st_rel_once got %b want 0", IFID_Flush); else passed++;
    total++; if (RedirectCount !== 16'd2) $display("FAIL st_cnt got %0d want 2", RedirectCount); else passed++;
  endtask

  task automatic test_priority_misalign();
    JumpReg = 1; JumpRegAddr = 32'h203; Jump = 1; JumpTarget = 26'h123;
    Branch = 1; JumpAmount = 16'h10; ID_PCPlus4 = 32'h500;
    #1;
    total++; if (MisalignErr !== 1'b0) $display("FAIL pr_mis_early got %b want 0", MisalignErr); else passed++;
    tick();
    clear_in();
    #1;
    total++; if (PC !== 32'h200) $display("FAIL pr_pc got %h want 200", PC); else passed++;
    total++; if (MisalignErr !== 1'b1) $display("FAIL pr_mis got %b want 1", MisalignErr); else passed++;
    tick();
    total++; if (MisalignErr !== 1'b0) $display("FAIL pr_mis_once got %b want 0", MisalignErr); else passed++;
    Jump = 1; JumpTarget = 26'h0ABCDE; ID_PCPlus4 = 32'hA000_0000; Branch = 1;
    tick();
    clear_in();
    #1;
    total++; if (PC !== 32'hA02A_F378) $display("FAIL pr_j got %h want a02af378", PC); else passed++;
  endtask

  task automatic test_wrap_and_reset_pending();
    ID_PCPlus4 = 32'hFFFF_FFFC; Branch = 1; JumpAmount = 16'd1;
    tick();
    clear_in();
    #1;
    total++; if (PC !== 32'h0) $display("FAIL wrap_pc got %h want 0", PC); else passed++;
    Stall = 1; Branch = 1; JumpAmount = 16'd8; ID_PCPlus4 = 32'h300;
    tick();
    total++; if (Pending !== 1'b1) $display("FAIL rp_pend got %b want 1", Pending); else passed++;
    Reset_n = 0;
    #1;
    total++; if (Pending !== 1'b0) $display("FAIL rp_pend_rst got %b want 0", Pending); else passed++;
    total++; if (PC !== 32'h0) $display("FAIL rp_pc_rst got %h want 0", PC); else passed++;
    total++; if (RedirectCount !== 16'h0) $display("FAIL rp_cnt got %h want 0", RedirectCount); else passed++;
    clear_in();
    Reset_n = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (IFID_Flush !== 1'b0) $display("FAIL rp_flush%0d got %b want 0", i, IFID_Flush); else passed++;
      tick();
    end
    total++; if (PC !== 32'h8) $display("FAIL rp_pc_after got %h want 8", PC); else passed++;
  endtask

  task automatic test_random();
    logic exp_flush;
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      Stall       = ($urandom_range(0, 2) == 0);
      Branch      = ($urandom_range(0, 3) == 0);
      Jump        = ($urandom_range(0, 5) == 0);
      JumpReg     = ($urandom_range(0, 5) == 0);
      JumpAmount  = 16'($urandom);
      JumpTarget  = 26'($urandom);
      JumpRegAddr = $urandom;
      ID_PCPlus4  = $urandom;
      #1;
      exp_flush = !Stall && (m_pend || Branch || Jump || JumpReg);
      total++; if (PC !== m_pc) $display("FAIL rnd_pc %0d got %h want %h", i, PC, m_pc); else passed++;
      total++; if (PCPlus4 !== m_pc + 32'd4) $display("FAIL rnd_pc4 %0d got %h want %h", i, PCPlus4, m_pc + 32'd4); else passed++;
      total++; if (Pending !== m_pend) $display("FAIL rnd_pend %0d got %b want %b", i, Pending, m_pend); else passed++;
      total++; if (IFID_Flush !== exp_flush) $display("FAIL rnd_flush %0d got %b want %b", i, IFID_Flush, exp_flush); else passed++;
      total++; if (MisalignErr !== m_mis) $display("FAIL rnd_mis %0d got %b want %b", i, MisalignErr, m_mis); else passed++;
      total++; if (RedirectCount !== 16'(m_cnt)) $display("FAIL rnd_cnt %0d got %0d want %0d", i, RedirectCount, m_cnt); else passed++;
      model_step();
      tick();
    end
    clear_in();
  endtask

  task automatic test_saturate();
    do_reset();
    Branch = 1; JumpAmount = 16'd0; ID_PCPlus4 = 32'h80;
    #1;
    total++; if (IFID_Flush !== 1'b1) $display("FAIL zero_flush got %b want 1", IFID_Flush); else passed++;
    tick();
    total++; if (PC !== 32'h80) $display("FAIL zero_pc got %h want 80", PC); else passed++;
    for (int i = 1; i < 65535; i++) tick();
    total++; if (RedirectCount !== 16'hFFFF) $display("FAIL sat_reach got %h want ffff", RedirectCount); else passed++;
    tick();
    tick();
    total++; if (RedirectCount !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", RedirectCount); else passed++;
    clear_in();
  endtask

  initial begin
    clear_in();
    Reset_n = 1;
    #2;
    test_reset();
    test_branch_back();
    test_stall_pending();
    test_priority_misalign();
    test_wrap_and_reset_pending();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
